// File: rtl/adpcm_main_sdiv_42s_11s_32_seq.sv
// ---------------------------------------------------------------------------
// adpcm_main_sdiv_42s_11s_32_seq
//
// Sequential signed divider with C truncating semantics.
// The quotient is rounded toward zero, and the remainder takes the sign of
// the dividend. Operands are captured as magnitudes plus sign bits. A
// radix-2 restoring loop of din0_WIDTH steps produces the unsigned quotient
// and remainder. One SIGN step applies the signs, and one DONE step
// publishes the result. From the accepting edge to done there are
// din0_WIDTH + 2 enabled edges.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   ce     in   clock enable; when low, every register holds
//   start  in   request, accepted only in IDLE on an enabled edge
//   din0   in   signed dividend (din0_WIDTH)
//   din1   in   signed divisor  (din1_WIDTH)
//   quot   out  signed quotient, low dout_WIDTH bits of the true quotient
//   rem    out  signed remainder (din1_WIDTH)
//   busy   out  high from acceptance through the DONE state
//   done   out  one enabled-cycle pulse when quot/rem/dbz/ovf are updated
//   dbz    out  divide by zero (quot = rem = 0, ovf = 0)
//   ovf    out  true quotient does not fit in dout_WIDTH signed bits
// ---------------------------------------------------------------------------
module adpcm_main_sdiv_42s_11s_32_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 42,
  parameter int din1_WIDTH = 11,
  parameter int dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  busy,
  output logic                  done,
  output logic                  dbz,
  output logic                  ovf
);

  localparam int DW = din0_WIDTH;  // dividend / quotient magnitude width
  localparam int VW = din1_WIDTH;  // divisor / remainder width
  localparam int QW = dout_WIDTH;  // published quotient width
  localparam int PW = DW + 1;      // partial remainder width
  localparam int HW = DW - QW + 2; // signed-quotient bits that must agree for no overflow

  localparam logic [5:0] CntLast = 6'(DW - 1);

  // ID is an instance tag only.
  if (ID < 0) begin : g_id_tag
  end

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StSign,
    StDone
  } state_e;

  state_e         r_state;
  logic [5:0]     r_cnt;
  // Dividend magnitude shifts out of the top.
  // Quotient bits shift in at the bottom.
  logic [DW-1:0]  r_dvd;
  logic [PW-1:0]  r_prem;
  // One bit wider than din1 so that |-2^(VW-1)| is representable.
  logic [VW:0]    r_dvs;
  logic           r_q_neg;
  logic           r_r_neg;
  logic [DW:0]    r_qs;
  logic [VW-1:0]  r_rs;
  logic [QW-1:0]  r_quot;
  logic [VW-1:0]  r_rem;
  logic           r_busy;
  logic           r_done;
  logic           r_dbz;
  logic           r_ovf;

  logic [DW-1:0]  w_dvd_abs;
  logic [VW:0]    w_dvs_sx;
  logic [VW:0]    w_dvs_abs;
  logic [PW-1:0]  w_shift;
  logic [PW-1:0]  w_dvs_ext;
  logic [PW-1:0]  w_trial;
  logic           w_fit;
  logic [DW:0]    w_q_mag;
  logic [VW-1:0]  w_r_mag;
  logic [DW:0]    w_qs;
  logic [VW-1:0]  w_rs;
  logic [HW-1:0]  w_hi;
  logic           w_ovf;

  always_comb begin
    // Operand magnitudes.
    // -2^(DW-1) negates to itself, which is the correct unsigned magnitude.
    w_dvd_abs = din0[DW-1] ? -din0 : din0;
    w_dvs_sx  = {din1[VW-1], din1};
    w_dvs_abs = w_dvs_sx[VW] ? -w_dvs_sx : w_dvs_sx;

    // One restoring step: shift in the next dividend bit, then try to subtract.
    w_shift   = {r_prem[PW-2:0], r_dvd[DW-1]};
    w_dvs_ext = {{(PW - VW - 1){1'b0}}, r_dvs};
    // A set top bit means the shifted value is far above any divisor.
    w_fit     = r_prem[PW-1] | (w_shift >= w_dvs_ext);
    w_trial   = w_shift - w_dvs_ext;

    // Sign application.
    // The remainder magnitude is below |din1| <= 2^(VW-1), so VW bits suffice.
    w_q_mag = {1'b0, r_dvd};
    w_r_mag = r_prem[VW-1:0];
    w_qs    = r_q_neg ? -w_q_mag : w_q_mag;
    w_rs    = r_r_neg ? -w_r_mag : w_r_mag;

    // The quotient fits in QW signed bits only when its sign bit and every
    // higher bit agree.
    w_hi  = r_qs[DW:QW-1];
    w_ovf = ~((&w_hi) | ~(|w_hi));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_prem  <= '0;
      r_dvs   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_qs    <= '0;
      r_rs    <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (ce) begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            r_dvd   <= w_dvd_abs;
            r_dvs   <= w_dvs_abs;
            r_prem  <= '0;
            r_q_neg <= din0[DW-1] ^ din1[VW-1];
            r_r_neg <= din0[DW-1];
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StCalc;
          end
        end

        StCalc: begin
          r_prem <= w_fit ? w_trial : w_shift;
          r_dvd  <= {r_dvd[DW-2:0], w_fit};
          if (r_cnt == CntLast) begin
            r_state <= StSign;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end

        StSign: begin
          r_qs    <= w_qs;
          r_rs    <= w_rs;
          r_state <= StDone;
        end

        StDone: begin
          // A zero divisor runs the full loop for fixed latency, but the
          // loop's result is discarded.
          if (r_dvs == '0) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b1;
            r_ovf  <= 1'b0;
          end else begin
            r_quot <= r_qs[QW-1:0];
            r_rem  <= r_rs;
            r_dbz  <= 1'b0;
            r_ovf  <= w_ovf;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign quot = r_quot;
  assign rem  = r_rem;
  assign busy = r_busy;
  assign done = r_done;
  assign dbz  = r_dbz;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_adpcm_main_sdiv_42s_11s_32_seq.sv
module tb_adpcm_main_sdiv_42s_11s_32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        start;
  logic [41:0] din0;
  logic [10:0] din1;
  logic [31:0] quot;
  logic [10:0] rem;
  logic        busy;
  logic        done;
  logic        dbz;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  adpcm_main_sdiv_42s_11s_32_seq #(
    .ID        (1),
    .din0_WIDTH(42),
    .din1_WIDTH(11),
    .dout_WIDTH(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .start(start),
    .din0 (din0),
    .din1 (din1),
    .quot (quot),
    .rem  (rem),
    .busy (busy),
    .done (done),
    .dbz  (dbz),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [41:0] a;
    logic [10:0] b;
    logic [31:0] q;
    logic [10:0] r;
    logic        dz;
    logic        ov;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit C-style division, which truncates toward zero.
  function automatic void model(input logic [41:0] a, input logic [10:0] b,
                                output logic [31:0] q, output logic [10:0] r,
                                output logic dz, output logic ov);
    longint sa;
    longint sb;
    longint lq;
    longint lr;
    sa = {{22{a[41]}}, a};
    sb = {{53{b[10]}}, b};
    if (sb == 0) begin
      q  = '0;
      r  = '0;
      dz = 1'b1;
      ov = 1'b0;
    end else begin
      lq = sa / sb;
      lr = sa % sb;
      dz = 1'b0;
      ov = (lq > 64'sd2147483647) || (lq < -64'sd2147483648);
      q  = lq[31:0];
      r  = lr[10:0];
    end
  endfunction

  // Issue one division.
  // Optionally stall ce for stall_len edges starting at post-accept edge
  // stall_at, and optionally pulse start with other operands at edge poke_at.
  // Returns in the cycle where done is high; lat counts every edge after
  // acceptance.
  task automatic run_op(input logic [41:0] a, input logic [10:0] b, input int stall_at,
                        input int stall_len, input int poke_at, output int lat);
    din0  = a;
    din1  = b;
    start = 1'b1;
    ce    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 300) begin
      ce = (lat >= stall_at && lat < stall_at + stall_len) ? 1'b0 : 1'b1;
      if (lat == poke_at) begin
        start = 1'b1;
        din0  = 42'd5;
        din1  = 11'd1;
      end
      tick();
      start = 1'b0;
      din0  = a;
      din1  = b;
      lat++;
      if (lat == 20) check("busy_mid_op", 64'(busy), 64'd1);
    end
    ce = 1'b1;
    if (lat >= 300) check("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic check_outs(input string name, input logic [31:0] q, input logic [10:0] r,
                            input logic dz, input logic ov);
    check({name, ".quot"}, 64'(quot), 64'(q));
    check({name, ".rem"}, 64'(rem), 64'(r));
    check({name, ".dbz"}, 64'(dbz), 64'(dz));
    check({name, ".ovf"}, 64'(ovf), 64'(ov));
  endtask

  initial begin
    int          lat;
    int          cyc_a;
    logic [31:0] eq;
    logic [10:0] er;
    logic        edz;
    logic        eov;
    logic [63:0] t;
    logic [41:0] ra;
    logic [10:0] rb;

    vecs[0]  = '{42'd1000, 11'd7, 32'd142, 11'd6, 1'b0, 1'b0};
    vecs[1]  = '{-42'd1000, 11'd7, -32'd142, -11'd6, 1'b0, 1'b0};
    vecs[2]  = '{42'd1000, -11'd7, -32'd142, 11'd6, 1'b0, 1'b0};
    vecs[3]  = '{-42'd1000, -11'd1024, 32'd0, -11'd1000, 1'b0, 1'b0};
    vecs[4]  = '{42'd12345, 11'd0, 32'd0, 11'd0, 1'b1, 1'b0};
    vecs[5]  = '{42'h200_0000_0000, -11'd1, 32'd0, 11'd0, 1'b0, 1'b1};
    vecs[6]  = '{42'h000_8000_0000, 11'd1, 32'h8000_0000, 11'd0, 1'b0, 1'b1};
    vecs[7]  = '{42'h3FF_8000_0000, 11'd1, 32'h8000_0000, 11'd0, 1'b0, 1'b0};
    vecs[8]  = '{42'd100, 11'd3, 32'd33, 11'd1, 1'b0, 1'b0};
    vecs[9]  = '{-42'd100, 11'd3, -32'd33, -11'd1, 1'b0, 1'b0};
    vecs[10] = '{42'h1FF_FFFF_FFFF, -11'd1024, 32'h8000_0001, 11'd1023, 1'b0, 1'b0};

    // Reset state, including while clocking with start asserted.
    reset = 1'b0;
    ce    = 1'b0;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    #1;
    check_outs("reset", 32'd0, 11'd0, 1'b0, 1'b0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    ce    = 1'b1;
    start = 1'b1;
    din0  = 42'd1000;
    din1  = 11'd7;
    tick();
    tick();
    check("reset_held.busy", 64'(busy), 64'd0);
    check("reset_held.done", 64'(done), 64'd0);
    start = 1'b0;
    reset = 1'b1;
    tick();

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, -1, 0, -1, lat);
      check($sformatf("vec%0d.latency", i), 64'(lat), 64'd44);
      check($sformatf("vec%0d.busy_at_done", i), 64'(busy), 64'd0);
      check_outs($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);
      tick();
      check($sformatf("vec%0d.done_pulse", i), 64'(done), 64'd0);
      check_outs($sformatf("vec%0d.hold", i), vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);
    end

    // Randomized operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      t  = {$urandom(), $urandom()};
      ra = t[41:0] >> $urandom_range(0, 41);
      if (t[63]) ra = -ra;
      rb = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 7) == 0) rb = t[62] ? 11'h400 : 11'd0;
      model(ra, rb, eq, er, edz, eov);
      run_op(ra, rb, -1, 0, -1, lat);
      check($sformatf("rnd%0d.latency", i), 64'(lat), 64'd44);
      check_outs($sformatf("rnd%0d(%0h/%0h)", i, ra, rb), eq, er, edz, eov);
      if (($urandom_range(0, 1)) == 1) tick();
    end

    // ce low for 5 edges mid-CALC delays done by exactly 5.
    run_op(42'd1000, 11'd7, 10, 5, -1, lat);
    check("stall.latency", 64'(lat), 64'd49);
    check_outs("stall", 32'd142, 11'd6, 1'b0, 1'b0);
    // The done pulse survives ce=0 until the next enabled edge.
    ce = 1'b0;
    tick();
    tick();
    tick();
    check("stall.done_held", 64'(done), 64'd1);
    ce = 1'b1;
    tick();
    check("stall.done_cleared", 64'(done), 64'd0);

    // start pulsed while busy is ignored.
    run_op(-42'd1000, 11'd7, -1, 0, 10, lat);
    check("poke.latency", 64'(lat), 64'd44);
    check_outs("poke", -32'd142, -11'd6, 1'b0, 1'b0);
    tick();
    check("poke.idle_after", 64'(busy), 64'd0);

    // Reset during CALC: outputs clear immediately and no done appears.
    run_op(42'd1000, 11'd7, -1, 0, -1, lat);
    din0  = 42'd999;
    din1  = 11'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (21) tick();
    check("rst_mid.busy_before", 64'(busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_outs("rst_mid", 32'd0, 11'd0, 1'b0, 1'b0);
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    tick();
    check("rst_mid.done_edge", 64'(done), 64'd0);
    reset = 1'b1;

    // The first edge after release accepts; back-to-back issue.
    run_op(42'd100, 11'd3, -1, 0, -1, lat);
    cyc_a = cyc;
    check("b2b_a.latency", 64'(lat), 64'd44);
    check_outs("b2b_a", 32'd33, 11'd1, 1'b0, 1'b0);
    run_op(-42'd100, 11'd3, -1, 0, -1, lat);
    check("b2b_b.latency", 64'(lat), 64'd44);
    check("b2b.interval", 64'(cyc - cyc_a), 64'd45);
    check_outs("b2b_b", -32'd33, -11'd1, 1'b0, 1'b0);
    tick();
    check("b2b_b.done_pulse", 64'(done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
